// File: rtl/alu_op_issuer.sv
// Command FIFO in front of an external combinational ALU. Each command is
// popped into registered ALU operands, executed for one cycle, and its result
// held in an output register until the consumer takes it.
module alu_op_issuer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_a,
    input  logic [5:0]  in_b,
    input  logic [1:0]  in_sel,
    output logic [5:0]  alu_a,
    output logic [5:0]  alu_b,
    output logic [1:0]  alu_sel,
    input  logic [11:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_result,
    output logic [1:0]  out_sel,
    output logic [4:0]  count,
    output logic        busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, next_state;
    logic [13:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [13:0]     head;
    logic            push, pop, load_out, clr_valid;

    // A full FIFO never accepts, even when a pop happens on the same edge.
    assign in_ready = (count < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (count != 5'd0) || (state != IDLE);

    // Command storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_sel, in_a, in_b};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load_out   = 1'b0;
        clr_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (count != 5'd0) begin
                    pop        = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                load_out   = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    clr_valid = 1'b1;
                    if (count != 5'd0) begin
                        pop        = 1'b1;
                        next_state = EXEC;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ALU operand registers; they change only when a command is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (pop) begin
            alu_sel <= head[13:12];
            alu_a   <= head[11:6];
            alu_b   <= head[5:0];
        end
    end

    // Result capture at the end of EXEC; held until the consumer accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
        end else if (load_out) begin
            out_result <= alu_result;
            out_sel    <= alu_sel;
            out_valid  <= 1'b1;
        end else if (clr_valid) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural ALU attached.
module tb_alu_op_issuer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_a, in_b;
    logic [1:0]  in_sel;
    logic [5:0]  alu_a, alu_b;
    logic [1:0]  alu_sel;
    logic [11:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_result;
    logic [1:0]  out_sel;
    logic [4:0]  count;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [1:0]  sel;
        logic [11:0] res;
    } vec_t;

    vec_t vecs [9];

    alu_op_issuer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_sel(out_sel),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    // External ALU.
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            2'b00: alu_result = {6'b0, alu_a} + {6'b0, alu_b};
            2'b01: alu_result = {6'b0, alu_a} - {6'b0, alu_b};
            2'b10: alu_result = 12'(alu_a) * 12'(alu_b);
            default: alu_result = {6'b0, alu_a & alu_b};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] b, input logic [1:0] s);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sel   = s;
    endtask

    // One command into an idle block with out_ready high: result after E2, idle after E3.
    task automatic run_single(input vec_t v);
        out_ready = 1'b1;
        drive(1'b1, v.a, v.b, v.sel);
        chk("single_in_ready", in_ready, 1);
        tick();                                  // E0: push
        drive(1'b0, 6'd0, 6'd0, 2'd0);
        chk("single_valid_e0", out_valid, 0);
        tick();                                  // E1: pop into EXEC
        chk("single_valid_e1", out_valid, 0);
        chk("single_busy_e1", busy, 1);
        tick();                                  // E2: result captured
        chk("single_valid_e2", out_valid, 1);
        chk("single_result", out_result, v.res);
        chk("single_sel", out_sel, v.sel);
        tick();                                  // E3: consumed, back to IDLE
        chk("single_valid_e3", out_valid, 0);
        chk("single_busy_e3", busy, 0);
    endtask

    logic [11:0] got_r [$];
    logic [1:0]  got_s [$];
    int          got_t [$];
    logic [11:0] exp_r [5];
    logic [1:0]  exp_s [5];
    logic        acc   [6];

    initial begin
        vecs[0] = '{6'd15, 6'd5,  2'b00, 12'd20};
        vecs[1] = '{6'd0,  6'd1,  2'b01, 12'd4095};
        vecs[2] = '{6'd63, 6'd63, 2'b10, 12'd3969};
        vecs[3] = '{6'd63, 6'd63, 2'b11, 12'd63};
        vecs[4] = '{6'd30, 6'd10, 2'b01, 12'd20};
        vecs[5] = '{6'd6,  6'd7,  2'b10, 12'd42};
        vecs[6] = '{6'd42, 6'd51, 2'b11, 12'd34};
        vecs[7] = '{6'd63, 6'd1,  2'b00, 12'd64};
        vecs[8] = '{6'd2,  6'd3,  2'b10, 12'd6};

        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 6'd0, 6'd0, 2'd0);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_alu_ops", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_out_regs", {out_result, out_sel}, 0);
        tick();
        tick();
        rst = 1'b0;

        // Table-driven single-command vectors; first push lands on the first edge after reset.
        for (int i = 0; i < 9; i++)
            run_single(vecs[i]);

        // Back-to-back mixed ops with out_ready held high.
        out_ready = 1'b1;
        got_r.delete(); got_s.delete(); got_t.delete();
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc < 4)
                drive(1'b1, vecs[4 + cyc].a, vecs[4 + cyc].b, vecs[4 + cyc].sel);
            else
                drive(1'b0, 6'd0, 6'd0, 2'd0);
            tick();
            if (out_valid) begin
                got_r.push_back(out_result);
                got_s.push_back(out_sel);
                got_t.push_back(cyc);
            end
        end
        chk("b2b_count", got_r.size(), 4);
        for (int i = 0; i < 4 && i < got_r.size(); i++) begin
            chk("b2b_result", got_r[i], vecs[4 + i].res);
            chk("b2b_sel", got_s[i], vecs[4 + i].sel);
            chk("b2b_time", got_t[i], 2 + 2 * i);
        end
        chk("b2b_idle", busy, 0);

        // Fill under backpressure: DEPTH+2 attempts, DEPTH+1 accepted.
        exp_r = '{12'd3, 12'd2, 12'd20, 12'd8, 12'd16};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1'b1, 6'd1,  6'd2,  2'd0);
                1: drive(1'b1, 6'd5,  6'd3,  2'd1);
                2: drive(1'b1, 6'd4,  6'd5,  2'd2);
                3: drive(1'b1, 6'd12, 6'd10, 2'd3);
                4: drive(1'b1, 6'd7,  6'd9,  2'd0);
                default: drive(1'b1, 6'd9, 6'd9, 2'd2);
            endcase
            acc[i] = in_ready;
            tick();
        end
        drive(1'b0, 6'd0, 6'd0, 2'd0);
        for (int i = 0; i < 6; i++)
            chk("full_accept", acc[i], (i < 5) ? 1 : 0);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, DEPTH);
        chk("full_valid", out_valid, 1);
        chk("full_head_result", out_result, 3);

        // Stall in RESP for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_result", out_result, 3);
            chk("stall_sel", out_sel, 0);
            chk("stall_count", count, DEPTH);
            chk("stall_valid", out_valid, 1);
        end

        // Release and drain.
        out_ready = 1'b1;
        got_r.delete(); got_s.delete();
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (out_valid) begin
                got_r.push_back(out_result);
                got_s.push_back(out_sel);
            end
            tick();
        end
        chk("drain_count", got_r.size(), 5);
        for (int i = 0; i < 5 && i < got_r.size(); i++) begin
            chk("drain_result", got_r[i], exp_r[i]);
            chk("drain_sel", got_s[i], exp_s[i]);
        end
        chk("drain_idle", busy, 0);

        // Reset while in EXEC with three commands queued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'(i + 10), 6'd1, 2'd0);
            tick();
        end
        drive(1'b1, 6'd20, 6'd1, 2'd0);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 6'd0, 6'd0, 2'd0);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_alu_a", alu_a, 11);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_alu_ops", {alu_a, alu_b, alu_sel}, 0);
        chk("async_rst_out_regs", {out_result, out_sel}, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        got_r.delete(); got_s.delete();
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (cyc == 0)
                drive(1'b1, 6'd2, 6'd3, 2'b10);
            else
                drive(1'b0, 6'd0, 6'd0, 2'd0);
            tick();
            if (out_valid) begin
                got_r.push_back(out_result);
                got_s.push_back(out_sel);
            end
        end
        chk("post_rst_count", got_r.size(), 1);
        if (got_r.size() > 0) begin
            chk("post_rst_result", got_r[0], 6);
            chk("post_rst_sel", got_s[0], 2);
        end
        chk("post_rst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  producer presents a command.
REQ-005 in_ready  output  1  block accepts a command this cycle.
REQ-006 in_a, in_b  input  6 each  operands.
REQ-007 in_sel  input  2  op code: 00 add, 01 sub, 10 mul, 11 AND.
REQ-008 alu_a, alu_b  output  6 each  registered operands driven to the ALU.
REQ-009 alu_sel  output  2  registered op code driven to the ALU.
REQ-010 alu_result  input  12  combinational ALU result for alu_a/alu_b/alu_sel.
REQ-011 out_valid  output  1  out_result holds a captured result.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_result  output  12  captured ALU result.
REQ-014 out_sel  output  2  op code that produced out_result.
REQ-015 count  output  5  current FIFO occupancy, 0..DEPTH.
REQ-016 busy  output  1  high when count != 0 or state != IDLE.

Function
REQ-017 Command FIFO SHALL store {in_sel, in_a, in_b} (14 bits) in arrival order.
REQ-018 in_ready SHALL equal (count < DEPTH), with no full-bypass: a full FIFO rejects a push even if a pop occurs in the same cycle.
REQ-019 A push SHALL occur on an edge where in_valid && in_ready; a pop SHALL occur on the edge the FSM leaves IDLE or RESP for EXEC.
REQ-020 On a simultaneous push and pop, count SHALL be unchanged and both entries SHALL be handled correctly, including pointer wrap-around at DEPTH.
REQ-021 FSM states SHALL be IDLE, EXEC, and RESP.
REQ-022 IDLE transitions:
- count != 0: pop the head into alu_a/alu_b/alu_sel and go to EXEC.
- otherwise: stay in IDLE.
REQ-023 EXEC SHALL last exactly one cycle: at its closing edge, latch alu_result into out_result and alu_sel into out_sel, set out_valid, and go to RESP.
REQ-024 RESP transitions:
- out_ready && count != 0: pop the next command, clear out_valid, and go to EXEC.
- out_ready && count == 0: clear out_valid and go to IDLE.
- !out_ready: stay in RESP.
REQ-025 While out_valid && !out_ready, out_result and out_sel SHALL hold stable.
REQ-026 alu_a/alu_b/alu_sel SHALL change only on a pop.
REQ-027 Latency: for a command pushed at edge E0 into an empty, idle block, out_valid SHALL be high after edge E2.
REQ-028 Throughput: with out_ready held high, one result SHALL be produced every 2 cycles.
REQ-029 Results SHALL exit in the same order commands were accepted; no command SHALL be dropped or duplicated.
REQ-030 The block SHALL NOT modify alu_result, which is defined by the ALU as:
- add: zero-extended sum.
- sub: difference modulo 2^12.
- mul: full 12-bit product.
- AND: 6-bit AND zero-extended.

Reset
REQ-031 While rst is high, the block SHALL:
- set FIFO pointers and count to 0;
- enter state IDLE;
- set alu_a, alu_b, alu_sel, out_result, and out_sel to 0;
- drive out_valid and busy to 0 and in_ready to 1.
REQ-032 Reset asserted mid-operation (EXEC or RESP, FIFO non-empty) SHALL discard all queued and in-flight commands immediately, without waiting for a clock edge.
REQ-033 After rst deasserts, the first rising edge SHALL be able to accept a push.

Verification
REQ-034 Single add: push (15, 5, 00) into idle block, out_ready=1 -> out_valid high 2 edges later, out_result=20, out_sel=00, then IDLE, busy=0.
REQ-035 Back-to-back mixed ops: push (30,10,01), (6,7,10), (42,51,11), (63,1,00) on consecutive cycles with out_ready=1 -> results 20, 42, 34, 64 in order, spaced 2 cycles apart.
REQ-036 Full/backpressure: out_ready=0, push DEPTH+2 commands -> in_ready low once count=DEPTH (with one op held in RESP), no loss; release out_ready -> all DEPTH+1 results drain in order.
REQ-037 Edge arithmetic: (0,1,01) -> 4095; (63,63,10) -> 3969; (63,63,11) -> 63.
REQ-038 Stall stability: hold out_ready=0 for 5 cycles in RESP -> out_result/out_sel unchanged, count unchanged apart from pushes.
REQ-039 Reset mid-op: assert rst asynchronously while in EXEC with count=3 -> outputs take reset values immediately; after release, a new push (2,3,10) -> out_result=6 with no stale results emitted.
